// File: rtl/id_rtype_pipe_pkg.sv
// Shared constants and types for the ID-stage R-type / OP-IMM decode slice.
package id_rtype_pipe_pkg;

  localparam int unsigned ALUOP_WIDTH = 5;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;

  localparam logic       WRITE_ENABLE  = 1'b1;
  localparam logic       WRITE_DISABLE = 1'b0;
  localparam logic       READ_ENABLE   = 1'b1;
  localparam logic       READ_DISABLE  = 1'b0;
  localparam logic [4:0] ZERO_REG      = 5'd0;

  typedef enum logic [1:0] {
    INST_TYPE_OTHER,
    INST_TYPE_R,
    INST_TYPE_I_ALU
  } inst_type_e;

endpackage

// File: rtl/id_rtype_pipe_fwd_mux.sv
// Per-source operand select (x0 / EX / MEM / regfile) with load-use hazard detection.
module id_fwd_mux
  import id_rtype_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic [4:0]      rs,
  input  logic            re,
  input  logic [XLEN-1:0] rdata,
  input  logic            ex_we,
  input  logic [4:0]      ex_waddr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic            ex_is_load,
  input  logic            mem_we,
  input  logic [4:0]      mem_waddr,
  input  logic [XLEN-1:0] mem_wdata,
  output logic [XLEN-1:0] operand,
  output logic            hazard
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = ex_we && (ex_waddr == rs);
  assign mem_hit = mem_we && (mem_waddr == rs);

  always_comb begin
    operand = rdata;
    hazard  = 1'b0;
    if (rs == ZERO_REG) begin
      operand = '0;
    end else if (FWD_EN && ex_hit && !ex_is_load) begin
      operand = ex_wdata;
    end else if (FWD_EN && mem_hit) begin
      operand = mem_wdata;
    end
    // Load data is not available until after EX, so an EX load hit always stalls.
    if (re == READ_ENABLE && rs != ZERO_REG) begin
      hazard = (ex_hit && (ex_is_load || !FWD_EN)) || (!FWD_EN && mem_hit);
    end
  end

endmodule

// File: rtl/id_rtype_pipe.sv
// ID stage for OP / OP-IMM (/ M-ext) instructions: decode, operand forwarding,
// load-use stall and a registered ID/EX slot with valid/ready handshake.
module id_rtype_pipe
  import id_rtype_pipe_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter bit          EN_IMM  = 1'b1,
  parameter bit          EN_MEXT = 1'b0,
  parameter bit          FWD_EN  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            inst_i,
  input  logic                   inst_valid_i,
  output logic                   inst_ready_o,
  output logic [4:0]             reg1_raddr_o,
  output logic [4:0]             reg2_raddr_o,
  output logic                   reg1_re_o,
  output logic                   reg2_re_o,
  input  logic [XLEN-1:0]        reg1_rdata_i,
  input  logic [XLEN-1:0]        reg2_rdata_i,
  input  logic                   ex_we_i,
  input  logic [4:0]             ex_waddr_i,
  input  logic [XLEN-1:0]        ex_wdata_i,
  input  logic                   ex_is_load_i,
  input  logic                   mem_we_i,
  input  logic [4:0]             mem_waddr_i,
  input  logic [XLEN-1:0]        mem_wdata_i,
  input  logic                   flush_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [XLEN-1:0]        op1_o,
  output logic [XLEN-1:0]        op2_o,
  output logic [ALUOP_WIDTH-1:0] alu_op_o,
  output logic                   reg_we_o,
  output logic [4:0]             reg_waddr_o,
  output logic                   illegal_o
);

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] funct7;
  logic [6:0] shift_f7;

  assign opcode = inst_i[6:0];
  assign rd     = inst_i[11:7];
  assign funct3 = inst_i[14:12];
  assign rs1    = inst_i[19:15];
  assign rs2    = inst_i[24:20];
  assign funct7 = inst_i[31:25];
  // On RV64 funct7[0] is shamt[5], so it must not take part in shift legality.
  assign shift_f7 = (XLEN == 64) ? {funct7[6:1], 1'b0} : funct7;

  inst_type_e             inst_type;
  logic                   legal;
  logic [ALUOP_WIDTH-1:0] alu_op_d;
  logic                   re1;
  logic                   re2;

  always_comb begin
    inst_type = INST_TYPE_OTHER;
    legal     = 1'b0;
    alu_op_d  = '0;
    re1       = READ_DISABLE;
    re2       = READ_DISABLE;
    if (opcode == OPCODE_OP) begin
      inst_type = INST_TYPE_R;
      re1       = READ_ENABLE;
      re2       = READ_ENABLE;
      alu_op_d  = {funct7[5], funct7[0], funct3};
      legal     = (funct7 == FUNCT7_BASE)
               || (funct7 == FUNCT7_ALT && (funct3 == FUNCT3_ADD_SUB || funct3 == FUNCT3_SRL_SRA))
               || (funct7 == FUNCT7_MEXT && EN_MEXT);
    end else if (opcode == OPCODE_OP_IMM && EN_IMM) begin
      inst_type = INST_TYPE_I_ALU;
      re1       = READ_ENABLE;
      // funct7 bits are immediate bits here; there are no M-ext immediate forms.
      alu_op_d  = {1'b0, 1'b0, funct3};
      case (funct3)
        FUNCT3_SLL:     legal = (shift_f7 == FUNCT7_BASE);
        FUNCT3_SRL_SRA: begin
          legal       = (shift_f7 == FUNCT7_BASE) || (shift_f7 == FUNCT7_ALT);
          alu_op_d[4] = (shift_f7 == FUNCT7_ALT);
        end
        default:        legal = 1'b1;
      endcase
    end
  end

  assign reg1_re_o    = re1;
  assign reg2_re_o    = re2;
  assign reg1_raddr_o = (re1 == READ_ENABLE) ? rs1 : ZERO_REG;
  assign reg2_raddr_o = (re2 == READ_ENABLE) ? rs2 : ZERO_REG;

  logic [XLEN-1:0] fwd1;
  logic [XLEN-1:0] fwd2;
  logic            haz1;
  logic            haz2;

  id_fwd_mux #(.XLEN(XLEN), .FWD_EN(FWD_EN)) u_fwd1 (
    .rs        (reg1_raddr_o),
    .re        (re1),
    .rdata     (reg1_rdata_i),
    .ex_we     (ex_we_i),
    .ex_waddr  (ex_waddr_i),
    .ex_wdata  (ex_wdata_i),
    .ex_is_load(ex_is_load_i),
    .mem_we    (mem_we_i),
    .mem_waddr (mem_waddr_i),
    .mem_wdata (mem_wdata_i),
    .operand   (fwd1),
    .hazard    (haz1)
  );

  id_fwd_mux #(.XLEN(XLEN), .FWD_EN(FWD_EN)) u_fwd2 (
    .rs        (reg2_raddr_o),
    .re        (re2),
    .rdata     (reg2_rdata_i),
    .ex_we     (ex_we_i),
    .ex_waddr  (ex_waddr_i),
    .ex_wdata  (ex_wdata_i),
    .ex_is_load(ex_is_load_i),
    .mem_we    (mem_we_i),
    .mem_waddr (mem_waddr_i),
    .mem_wdata (mem_wdata_i),
    .operand   (fwd2),
    .hazard    (haz2)
  );

  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] op2_d;
  logic            reg_we_d;
  logic            hazard;
  logic            slot_free;
  logic            accept;

  assign imm       = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
  assign op2_d     = (inst_type == INST_TYPE_I_ALU) ? imm : fwd2;
  assign reg_we_d  = (legal && rd != ZERO_REG) ? WRITE_ENABLE : WRITE_DISABLE;
  assign hazard    = haz1 || haz2;
  assign slot_free = !valid_o || ready_i;
  assign inst_ready_o = slot_free && !hazard && !flush_i;
  assign accept    = inst_valid_i && inst_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o     <= 1'b0;
      op1_o       <= '0;
      op2_o       <= '0;
      alu_op_o    <= '0;
      reg_we_o    <= WRITE_DISABLE;
      reg_waddr_o <= ZERO_REG;
      illegal_o   <= 1'b0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (accept) begin
      valid_o     <= 1'b1;
      op1_o       <= fwd1;
      op2_o       <= op2_d;
      alu_op_o    <= alu_op_d;
      reg_we_o    <= reg_we_d;
      reg_waddr_o <= rd;
      illegal_o   <= !legal;
    end else if (slot_free) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_rtype_pipe.sv
// Directed + randomized bench for id_rtype_pipe against a mnemonic-level reference model.
module tb_id_rtype_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic        inst_valid_i;
  logic        inst_ready_o;
  logic [4:0]  reg1_raddr_o, reg2_raddr_o;
  logic        reg1_re_o, reg2_re_o;
  logic [31:0] reg1_rdata_i, reg2_rdata_i;
  logic        ex_we_i, ex_is_load_i, mem_we_i;
  logic [4:0]  ex_waddr_i, mem_waddr_i;
  logic [31:0] ex_wdata_i, mem_wdata_i;
  logic        flush_i, ready_i;
  logic        valid_o, reg_we_o, illegal_o;
  logic [31:0] op1_o, op2_o;
  logic [4:0]  alu_op_o, reg_waddr_o;

  // Second instance with the M extension enabled; shares all inputs.
  logic        m_inst_ready_o, m_reg1_re_o, m_reg2_re_o;
  logic [4:0]  m_reg1_raddr_o, m_reg2_raddr_o;
  logic        m_valid_o, m_reg_we_o, m_illegal_o;
  logic [31:0] m_op1_o, m_op2_o;
  logic [4:0]  m_alu_op_o, m_reg_waddr_o;

  logic [31:0] regs [32];
  assign reg1_rdata_i = regs[reg1_raddr_o];
  assign reg2_rdata_i = regs[reg2_raddr_o];

  always #5 clk = ~clk;

  id_rtype_pipe #(.XLEN(32), .EN_IMM(1'b1), .EN_MEXT(1'b0), .FWD_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
    .reg1_raddr_o(reg1_raddr_o), .reg2_raddr_o(reg2_raddr_o), .reg1_re_o(reg1_re_o), .reg2_re_o(reg2_re_o),
    .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
    .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
    .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
    .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i), .op1_o(op1_o), .op2_o(op2_o),
    .alu_op_o(alu_op_o), .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .illegal_o(illegal_o)
  );

  id_rtype_pipe #(.XLEN(32), .EN_IMM(1'b1), .EN_MEXT(1'b1), .FWD_EN(1'b1)) u_dut_m (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_valid_i(inst_valid_i), .inst_ready_o(m_inst_ready_o),
    .reg1_raddr_o(m_reg1_raddr_o), .reg2_raddr_o(m_reg2_raddr_o), .reg1_re_o(m_reg1_re_o), .reg2_re_o(m_reg2_re_o),
    .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
    .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
    .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
    .flush_i(flush_i), .valid_o(m_valid_o), .ready_i(ready_i), .op1_o(m_op1_o), .op2_o(m_op2_o),
    .alu_op_o(m_alu_op_o), .reg_we_o(m_reg_we_o), .reg_waddr_o(m_reg_waddr_o), .illegal_o(m_illegal_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic       reads1;
    logic       reads2;
    logic       is_imm;
    logic       legal;
    logic [4:0] alu;
  } dec_t;

  // Reference decode written per mnemonic group (EN_IMM=1, XLEN=32).
  function automatic dec_t ref_decode(input logic [31:0] ins, input bit mext);
    dec_t d;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    opc = ins[6:0];
    f7  = ins[31:25];
    f3  = ins[14:12];
    d   = '0;
    if (opc == 7'h33) begin
      d.reads1 = 1'b1;
      d.reads2 = 1'b1;
      d.alu    = {f7[5], f7[0], f3};
      if (f7 == 7'h00)      d.legal = 1'b1;
      else if (f7 == 7'h20) d.legal = (f3 == 3'd0) || (f3 == 3'd5);
      else if (f7 == 7'h01) d.legal = mext;
    end else if (opc == 7'h13) begin
      d.reads1 = 1'b1;
      d.is_imm = 1'b1;
      d.alu    = {1'b0, 1'b0, f3};
      if (f3 == 3'd1)      d.legal = (f7 == 7'h00);
      else if (f3 == 3'd5) begin
        d.legal = (f7 == 7'h00) || (f7 == 7'h20);
        if (f7 == 7'h20) d.alu = 5'b10101;
      end else             d.legal = 1'b1;
    end
    return d;
  endfunction

  function automatic logic [31:0] ref_operand(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (ex_we_i && ex_waddr_i == rs && !ex_is_load_i) return ex_wdata_i;
    if (mem_we_i && mem_waddr_i == rs) return mem_wdata_i;
    return regs[rs];
  endfunction

  function automatic bit ref_stall(input dec_t d, input logic [4:0] r1, input logic [4:0] r2);
    bit s;
    s = 1'b0;
    if (ex_we_i && ex_is_load_i) begin
      if (d.reads1 && r1 != 5'd0 && r1 == ex_waddr_i) s = 1'b1;
      if (d.reads2 && r2 != 5'd0 && r2 == ex_waddr_i) s = 1'b1;
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    ex_we_i = 1'b0; ex_waddr_i = '0; ex_wdata_i = '0; ex_is_load_i = 1'b0;
    mem_we_i = 1'b0; mem_waddr_i = '0; mem_wdata_i = '0;
  endtask

  // Slot model state for the random phase.
  logic        m_valid, m_we, m_ill;
  logic [31:0] m_op1, m_op2;
  logic [4:0]  m_alu, m_waddr;

  initial begin
    dec_t        d;
    logic [31:0] ins, rnd;
    logic [6:0]  f7;
    bit          stall, rdy_exp, free;

    for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3);
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    rst = 1'b1; flush_i = 1'b0; ready_i = 1'b1; inst_valid_i = 1'b0;
    inst_i = 32'h002081B3;
    clear_fwd();
    #12;
    chk("rst_valid", valid_o, 0);
    chk("rst_op1", op1_o, 0);
    chk("rst_op2", op2_o, 0);
    chk("rst_alu", alu_op_o, 0);
    chk("rst_we", reg_we_o, 0);
    chk("rst_waddr", reg_waddr_o, 0);
    chk("rst_ill", illegal_o, 0);
    chk("rst_comb_raddr1", reg1_raddr_o, 1);
    chk("rst_comb_raddr2", reg2_raddr_o, 2);
    @(negedge clk); rst = 1'b0;

    // ADD x3,x1,x2
    @(posedge clk); #1;
    inst_valid_i = 1'b1;
    chk("add_ready", inst_ready_o, 1);
    tick();
    chk("add_valid", valid_o, 1);
    chk("add_op1", op1_o, 5);
    chk("add_op2", op2_o, 7);
    chk("add_alu", alu_op_o, 5'b00000);
    chk("add_waddr", reg_waddr_o, 3);
    chk("add_we", reg_we_o, 1);

    // SUB with EX and MEM both hitting rs1
    inst_i = 32'h402081B3;
    ex_we_i = 1'b1; ex_waddr_i = 5'd1; ex_wdata_i = 32'h10;
    mem_we_i = 1'b1; mem_waddr_i = 5'd1; mem_wdata_i = 32'h20;
    tick();
    chk("sub_op1_ex_wins", op1_o, 32'h10);
    chk("sub_op2", op2_o, 7);
    chk("sub_alu", alu_op_o, 5'b10000);

    // Load-use stall, then release
    inst_i = 32'h002081B3;
    mem_we_i = 1'b0; ex_is_load_i = 1'b1; ex_wdata_i = 32'h33;
    #1 chk("lu_ready", inst_ready_o, 0);
    tick();
    chk("lu_bubble", valid_o, 0);
    ex_is_load_i = 1'b0;
    #1 chk("lu_release_ready", inst_ready_o, 1);
    tick();
    chk("lu_accept_valid", valid_o, 1);
    chk("lu_accept_op1", op1_o, 32'h33);
    clear_fwd();

    // Back-pressure: slot held while inst_i changes
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inst_i = (i == 0) ? 32'h407302B3 : (i == 1) ? 32'hFFF08213 : 32'h0020E1B3;
      #1 chk("hold_ready", inst_ready_o, 0);
      tick();
      chk("hold_valid", valid_o, 1);
      chk("hold_op1", op1_o, 32'h33);
      chk("hold_op2", op2_o, 7);
      chk("hold_alu", alu_op_o, 0);
    end
    ready_i = 1'b1;

    // OP-IMM: ADDI x4,x1,-1 and SRAI x4,x1,3
    inst_i = 32'hFFF08213;
    #1 chk("addi_re2", reg2_re_o, 0);
    chk("addi_raddr2", reg2_raddr_o, 0);
    tick();
    chk("addi_op1", op1_o, 5);
    chk("addi_op2", op2_o, 32'hFFFFFFFF);
    chk("addi_waddr", reg_waddr_o, 4);
    inst_i = 32'h4030D213;
    tick();
    chk("srai_alu", alu_op_o, 5'b10101);
    chk("srai_ill", illegal_o, 0);

    // MUL: illegal without M, decoded with M
    inst_i = 32'h022081B3;
    tick();
    chk("mul_ill", illegal_o, 1);
    chk("mul_we", reg_we_o, 0);
    chk("mul_valid", valid_o, 1);
    chk("mext_ill", m_illegal_o, 0);
    chk("mext_alu", m_alu_op_o, 5'b01000);
    chk("mext_we", m_reg_we_o, 1);

    // Flush drops incoming instruction
    inst_i = 32'h002081B3;
    flush_i = 1'b1;
    #1 chk("flush_ready", inst_ready_o, 0);
    tick();
    chk("flush_valid", valid_o, 0);
    flush_i = 1'b0;

    // Reset asserted mid-stall
    tick();
    chk("pre_stall_valid", valid_o, 1);
    ready_i = 1'b0; ex_we_i = 1'b1; ex_waddr_i = 5'd2; ex_is_load_i = 1'b1;
    tick();
    chk("stall_valid", valid_o, 1);
    #2 rst = 1'b1;
    #1 chk("async_rst_valid", valid_o, 0);
    #1 rst = 1'b0;
    clear_fwd();
    ready_i = 1'b1;
    inst_valid_i = 1'b0;

    // Randomized phase
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    @(posedge clk); #1;
    rst = 1'b1; #1 rst = 1'b0;
    m_valid = 1'b0; m_we = 1'b0; m_ill = 1'b0; m_op1 = '0; m_op2 = '0; m_alu = '0; m_waddr = '0;
    for (int n = 0; n < 400; n++) begin
      rnd = $urandom;
      case (rnd[1:0])
        2'd0, 2'd1: begin
          case (rnd[3:2])
            2'd0: f7 = 7'h00;
            2'd1: f7 = 7'h20;
            2'd2: f7 = 7'h01;
            default: f7 = rnd[10:4];
          endcase
          ins = {f7, 2'b00, rnd[13:11], 2'b00, rnd[16:14], rnd[19:17], 2'b00, rnd[22:20], 7'h33};
        end
        2'd2: begin
          ins = $urandom;
          ins[6:0] = 7'h13;
          ins[19:15] = {2'b00, rnd[6:4]};
          if (rnd[3:2] == 2'd0) ins[31:25] = 7'h00;
          else if (rnd[3:2] == 2'd1) ins[31:25] = 7'h20;
        end
        default: ins = $urandom;
      endcase
      inst_i       = ins;
      inst_valid_i = (rnd[25:24] != 2'b00);
      ready_i      = (rnd[27:26] != 2'b00);
      flush_i      = (rnd[31:28] == 4'hF);
      rnd = $urandom;
      ex_we_i      = rnd[0];
      ex_waddr_i   = {2'b00, rnd[3:1]};
      ex_is_load_i = (rnd[5:4] == 2'b11);
      mem_we_i     = rnd[6];
      mem_waddr_i  = {2'b00, rnd[9:7]};
      ex_wdata_i   = $urandom;
      mem_wdata_i  = $urandom;

      d       = ref_decode(ins, 1'b0);
      stall   = ref_stall(d, ins[19:15], ins[24:20]);
      free    = !m_valid || ready_i;
      rdy_exp = free && !stall && !flush_i;
      #1;
      chk("rnd_ready", inst_ready_o, rdy_exp);
      chk("rnd_raddr1", reg1_raddr_o, d.reads1 ? ins[19:15] : 5'd0);
      chk("rnd_raddr2", reg2_raddr_o, d.reads2 ? ins[24:20] : 5'd0);
      if (flush_i) m_valid = 1'b0;
      else if (inst_valid_i && rdy_exp) begin
        m_valid = 1'b1;
        m_ill   = !d.legal;
        m_we    = d.legal && (ins[11:7] != 5'd0);
        m_waddr = ins[11:7];
        m_alu   = d.alu;
        m_op1   = ref_operand(ins[19:15]);
        m_op2   = d.is_imm ? {{20{ins[31]}}, ins[31:20]} : ref_operand(ins[24:20]);
      end else if (free) m_valid = 1'b0;
      tick();
      chk("rnd_valid", valid_o, m_valid);
      chk("rnd_ill", illegal_o, m_ill);
      chk("rnd_we", reg_we_o, m_we);
      chk("rnd_waddr", reg_waddr_o, m_waddr);
      if (!m_ill) begin
        chk("rnd_op1", op1_o, m_op1);
        chk("rnd_op2", op2_o, m_op2);
        chk("rnd_alu", alu_op_o, m_alu);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_rtype_pipe.md
Name: id_rtype_pipe

Overview:
Parametrised successor to the combinational R-type decode slice. It decodes OP (R-type) and, optionally, OP-IMM and M-extension instructions, then resolves operands with EX/MEM forwarding and detects load-use hazards. It registers the result into an ID/EX pipeline slot with a valid/ready handshake. It sits between the IF/ID register and the EX stage, and drives the regfile read ports directly.

Parameters:
XLEN, 32, operand/result width (32 or 64); feeds RDATA_WIDTH-sized ports.
EN_IMM, 1, 1 = also decode OP-IMM (I-type ALU, incl. shifts); 0 = treat as illegal.
EN_MEXT, 0, 1 = accept funct7=0000001 (MUL/DIV family); 0 = illegal.
FWD_EN, 1, 1 = forwarding from EX/MEM enabled; 0 = regfile data only, hazards stall instead.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
inst_i  in  32  instruction from IF/ID
inst_valid_i  in  1  inst_i holds a valid instruction
inst_ready_o  out  1  block accepts inst_i this cycle
reg1_raddr_o / reg2_raddr_o  out  5 each  regfile read addresses (combinational from inst_i)
reg1_re_o / reg2_re_o  out  1 each  read enables
reg1_rdata_i / reg2_rdata_i  in  XLEN each  regfile read data (same cycle)
ex_we_i, ex_waddr_i[5], ex_wdata_i[XLEN], ex_is_load_i  in  EX-stage writeback info
mem_we_i, mem_waddr_i[5], mem_wdata_i[XLEN]  in  MEM-stage writeback info
flush_i  in  1  kill the held slot and any incoming instruction
valid_o  out  1  ID/EX slot valid
ready_i  in  1  EX accepts slot
op1_o / op2_o  out  XLEN each  resolved operands (op2 = sign-extended imm for OP-IMM)
alu_op_o  out  5  {funct7[5], funct7[0], funct3}; funct7[5] is forced to 0 for OP-IMM except SRAI
reg_we_o  out  1  destination write enable (0 when rd=x0)
reg_waddr_o  out  5  rd
illegal_o  out  1  registered; slot holds an undecodable instruction

Behaviour:
- Reset (async, rst=1): valid_o=0, op1_o=op2_o=0, alu_op_o=0, reg_we_o=0, reg_waddr_o=ZERO_REG, illegal_o=0. Combinational outputs follow inst_i immediately after reset.
- Decode is combinational:
  - OP: rs1 and rs2 read.
  - OP-IMM: rs1 read only; reg2_re_o=0 and reg2_raddr_o=0.
  - Anything else: both read enables 0 and addresses 0.
- Legal funct7 for OP: 0000000; 0100000 only with funct3 000 or 101; 0000001 only if EN_MEXT.
- Legal funct7 for OP-IMM shifts: 0000000, or 0100000 for SRAI. For XLEN=64, shamt is 6 bits and funct7[0] belongs to shamt.
- Illegal instructions: the slot is loaded with illegal_o=1, reg_we_o=0, valid_o=1. Downstream traps.
- Operand select per source (FWD_EN=1), in priority order:
  1. rs==0 gives 0.
  2. ex_we_i && ex_waddr_i==rs && !ex_is_load_i gives ex_wdata_i.
  3. mem_we_i && mem_waddr_i==rs gives mem_wdata_i.
  4. Otherwise reg*_rdata_i.
- Hazard (stall) when a read-enabled, nonzero rs matches ex_waddr_i with ex_we_i=1 and either ex_is_load_i=1 or FWD_EN=0. With FWD_EN=0, a MEM match also stalls.
- Handshake:
  - slot_free = !valid_o || ready_i.
  - inst_ready_o = slot_free && !hazard && !flush_i.
  - Accept (inst_valid_i && inst_ready_o): load the slot, valid_o=1 next cycle. Latency is 1 cycle.
  - slot_free with no accept: valid_o=0 next cycle. A hazard therefore inserts a bubble.
  - valid_o && !ready_i: all slot outputs are held stable.
- flush_i: valid_o=0 next cycle regardless of ready_i or hazard; the incoming instruction is dropped. flush_i has priority over accept.
- Simultaneous EX and MEM hit on the same rs: EX wins. A hazard on rs1 alone stalls even if rs2 is clean.

Decomposition:
- defines.v gets the following new constants:
  - INST_TYPE_I_ALU
  - FUNCT7_BASE, FUNCT7_ALT, FUNCT7_MEXT
  - ALUOP_WIDTH (5)
- Existing constants are reused: WRITE_ENABLE/DISABLE, READ_ENABLE/DISABLE, ZERO_REG.
- One sub-module, id_fwd_mux: the per-operand priority select, instantiated twice. It takes rs, the re enable, regfile data and EX/MEM info, and returns the operand plus a hazard bit.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), regfile 5/7, no forwarding, ready_i=1 -> next cycle: valid_o=1, op1=5, op2=7, alu_op=00000, reg_waddr=3, reg_we=1.
- SUB x3,x1,x2 with ex_we=1, ex_waddr=1, ex_wdata=0x10, mem_waddr=1, mem_wdata=0x20 -> op1=0x10 (EX beats MEM), alu_op=10000.
- ADD using x1 while EX holds a load to x1 -> inst_ready_o=0, next cycle valid_o=0; drop ex_is_load_i -> instruction accepted, valid_o=1 one cycle later.
- valid_o=1, ready_i=0 for 3 cycles while inst_i changes -> op1/op2/alu_op unchanged, inst_ready_o=0 throughout.
- funct7=0000001 with EN_MEXT=0 -> illegal_o=1, reg_we_o=0. With EN_MEXT=1 and MUL -> alu_op=01000, illegal_o=0.
- flush_i=1 together with inst_valid_i=1 -> valid_o=0 next cycle. Assert rst mid-stall -> valid_o=0 immediately, without waiting for a clock edge.
